// File: rtl/writeback_queue_pkg.sv
// Shared types for the register-file writeback path.
// Holds the register write bundle, queue entry and producer offer types.
// Optional bypass lookup in writeback_queue is enabled by WBQ_BYPASS_EN.
package writeback_queue_pkg;

   localparam int WBQ_DEPTH_DEFAULT = 4;
   localparam int REG_AW            = 5;
   localparam int XLEN              = 32;

   // Single write port of the integer register file.
   typedef struct packed {
      logic              wren;
      logic [REG_AW-1:0] waddr;
      logic [XLEN-1:0]   wdata;
   } register_write_in_type;

   // One pending register write held in the queue.
   typedef struct packed {
      logic [REG_AW-1:0] waddr;
      logic [XLEN-1:0]   wdata;
   } wbq_entry_type;

   // Result offered by a producer (ALU or LSU).
   typedef struct packed {
      logic              valid;
      logic [REG_AW-1:0] waddr;
      logic [XLEN-1:0]   wdata;
   } wbq_in_type;

   // Writes to x0 are architecturally discarded.
   function automatic logic is_x0(input logic [REG_AW-1:0] addr);
      return (addr == '0);
   endfunction

endpackage

// File: rtl/wbq_match.sv
// Youngest-match search of queued writes for one register read address.
// Latency: purely combinational.
// Backpressure: none; observes queue state only.
module wbq_match
   import writeback_queue_pkg::*;
#(
   parameter int DEPTH = WBQ_DEPTH_DEFAULT
)
(
   input  wbq_entry_type                entries [DEPTH],
   input  logic [$clog2(DEPTH)-1:0]     head,
   input  logic [$clog2(DEPTH):0]       count,
   input  logic [REG_AW-1:0]            raddr,
   output logic                         hit,
   output logic [XLEN-1:0]              data
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   // Walk from oldest to youngest so the last match seen (the youngest) wins.
   always_comb begin
      hit  = 1'b0;
      data = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if ((CNT_W'(i) < count) && !is_x0(raddr) &&
             (entries[head + PTR_W'(i)].waddr == raddr)) begin
            hit  = 1'b1;
            data = entries[head + PTR_W'(i)].wdata;
         end
      end
   end

endmodule

// File: rtl/writeback_queue.sv
// In-order queue merging ALU and LSU results onto the single register-file write port.
// Latency: entry accepted at edge N is presented during N..N+1 and written at edge N+1.
// Backpressure: ready from registered occupancy only; ALU has priority, LSU needs a second free slot.
// Optional: WBQ_BYPASS_EN adds two read-address lookups forwarding the youngest queued value.
module writeback_queue
   import writeback_queue_pkg::*;
#(
   parameter int DEPTH = WBQ_DEPTH_DEFAULT
)
(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   alu_valid,
   input  logic [REG_AW-1:0]      alu_waddr,
   input  logic [XLEN-1:0]        alu_wdata,
   output logic                   alu_ready,
   input  logic                   lsu_valid,
   input  logic [REG_AW-1:0]      lsu_waddr,
   input  logic [XLEN-1:0]        lsu_wdata,
   output logic                   lsu_ready,
   output register_write_in_type  register_win,
   output logic [$clog2(DEPTH):0] count,
   output logic                   empty
`ifdef WBQ_BYPASS_EN
   ,
   input  logic [REG_AW-1:0]      byp_raddr1,
   input  logic [REG_AW-1:0]      byp_raddr2,
   output logic                   byp_hit1,
   output logic                   byp_hit2,
   output logic [XLEN-1:0]        byp_data1,
   output logic [XLEN-1:0]        byp_data2
`endif
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   wbq_in_type          alu_in;
   wbq_in_type          lsu_in;
   wbq_entry_type       mem [DEPTH];
   logic [PTR_W-1:0]    head;
   logic [PTR_W-1:0]    tail;
   logic [CNT_W-1:0]    cnt_q;
   logic [CNT_W-1:0]    free_slots;
   logic [CNT_W-1:0]    lsu_need;
   logic                alu_fire;
   logic                lsu_fire;
   logic                alu_store;
   logic                lsu_store;
   logic [1:0]          n_stored;
   logic [PTR_W-1:0]    lsu_slot;
   logic                drain;

   // Bundle producer offers for uniform handling below.
   always_comb begin
      alu_in = '{valid: alu_valid, waddr: alu_waddr, wdata: alu_wdata};
      lsu_in = '{valid: lsu_valid, waddr: lsu_waddr, wdata: lsu_wdata};
   end

   // Ready/accept decisions; a same-cycle drain is deliberately not credited.
   always_comb begin
      free_slots = CNT_W'(DEPTH) - cnt_q;
      alu_ready  = (free_slots != '0);
      alu_fire   = alu_in.valid && alu_ready;
      lsu_need   = CNT_W'(1) + CNT_W'(alu_fire);
      lsu_ready  = (free_slots >= lsu_need);
      lsu_fire   = lsu_in.valid && lsu_ready;
      // x0 writes are acknowledged but never occupy a slot.
      alu_store  = alu_fire && !is_x0(alu_in.waddr);
      lsu_store  = lsu_fire && !is_x0(lsu_in.waddr);
      n_stored   = 2'(alu_store) + 2'(lsu_store);
      // ALU entry is older, so LSU lands behind it only if ALU actually stored.
      lsu_slot   = tail + PTR_W'(alu_store);
      drain      = (cnt_q != '0);
   end

   // Entry storage; contents are don't-care outside head..tail-1, so no reset.
   always_ff @(posedge clk) begin
      if (alu_store) begin
         mem[tail] <= '{waddr: alu_in.waddr, wdata: alu_in.wdata};
      end
      if (lsu_store) begin
         mem[lsu_slot] <= '{waddr: lsu_in.waddr, wdata: lsu_in.wdata};
      end
   end

   // Pointer and occupancy bookkeeping; pointers wrap naturally.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         head  <= '0;
         tail  <= '0;
         cnt_q <= '0;
      end else begin
         tail  <= tail + PTR_W'(n_stored);
         head  <= head + PTR_W'(drain);
         cnt_q <= cnt_q + CNT_W'(n_stored) - CNT_W'(drain);
      end
   end

   // Present the head entry to the register file; all zero while empty.
   always_comb begin
      register_win = '0;
      if (drain) begin
         register_win.wren  = 1'b1;
         register_win.waddr = mem[head].waddr;
         register_win.wdata = mem[head].wdata;
      end
   end

   // Status outputs.
   always_comb begin
      count = cnt_q;
      empty = (cnt_q == '0);
   end

`ifdef WBQ_BYPASS_EN
   wbq_match #(.DEPTH(DEPTH)) u_match1 (
      .entries (mem),
      .head    (head),
      .count   (cnt_q),
      .raddr   (byp_raddr1),
      .hit     (byp_hit1),
      .data    (byp_data1)
   );

   wbq_match #(.DEPTH(DEPTH)) u_match2 (
      .entries (mem),
      .head    (head),
      .count   (cnt_q),
      .raddr   (byp_raddr2),
      .hit     (byp_hit2),
      .data    (byp_data2)
   );
`endif

endmodule
